// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel arbitrated stream mux with a registered output.
// Selection is round-robin, fixed-priority or directed by an explicit index.
module rr_stream_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 32,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    input  logic               out_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_chan;
    logic [SELW-1:0]  r_ptr;

    logic             w_load_en;
    logic             w_found;
    logic [SELW-1:0]  w_grant;
    logic [SELW:0]    w_sum;
    logic [N-1:0]     w_rot;
    logic [WIDTH-1:0] w_data;
    logic [SELW-1:0]  w_ptr_nxt;

    assign w_load_en = !r_valid || out_ready;

    // w_rot[i] is the valid of channel (ptr+i) mod N
    always_comb begin
        w_rot   = N'({in_valid, in_valid} >> r_ptr);
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        unique case (1'b1)
            (mode == 2'b00): begin
                for (int i = 0; i < N; i++) begin
                    if (!w_found && w_rot[i]) begin
                        w_found = 1'b1;
                        w_sum   = {1'b0, r_ptr} + (SELW+1)'(i);
                        if (w_sum >= (SELW+1)'(N)) begin
                            w_sum = w_sum - (SELW+1)'(N);
                        end
                        w_grant = w_sum[SELW-1:0];
                    end
                end
            end
            (mode == 2'b01): begin
                for (int i = 0; i < N; i++) begin
                    if (!w_found && in_valid[i]) begin
                        w_found = 1'b1;
                        w_grant = SELW'(i);
                    end
                end
            end
            default: begin
                for (int i = 0; i < N; i++) begin
                    if (sel == SELW'(i) && in_valid[i]) begin
                        w_found = 1'b1;
                        w_grant = SELW'(i);
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_data   = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SELW'(i)) begin
                w_data      = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = reset_n && w_load_en && w_found;
            end
        end
    end

    assign w_ptr_nxt = (w_grant == SELW'(N-1)) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_ptr   <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_data  <= w_data;
                r_chan  <= w_grant;
                if (mode == 2'b00) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_chan  = r_chan;

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output stage and valid/ready handshakes on every channel.
- It generalises the combinational one-hot-select mux family into an arbitrated, back-pressured selector.
- Three selection modes: round-robin, fixed-priority, and directed (explicit index select).
- Used for shared result buses, such as multiple functional units writing one register-file write port.

Parameters:
- WIDTH, 32, data bits per channel
- N, 32, number of input channels (2..64)
- SELW, $clog2(N), width of channel index fields

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- mode  input  2  00 round-robin, 01 fixed-priority (lowest index wins), 10 directed, 11 reserved (behaves as directed)
- sel  input  SELW  channel index used in directed mode
- in_valid  input  N  per-channel valid
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_ready  output  N  per-channel ready, at most one bit high
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected word
- out_chan  output  SELW  index of the channel that supplied out_data
- out_ready  input  1  downstream accepts out_data this cycle

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. While reset_n=0, in_ready=0.
- load_en = !out_valid || out_ready. The output register can accept a word in the same cycle it is drained, which gives full throughput of 1 word/cycle.
- Grant g is combinational from in_valid, mode, sel and ptr:
  - Round-robin: first k with in_valid[k], scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N).
  - Fixed-priority: lowest k with in_valid[k].
  - Directed: g=sel if sel<N and in_valid[sel]. sel>=N means no grant.
- in_ready[g]=load_en when a grant exists; all other in_ready bits are 0. in_ready never depends on out_valid of the same channel, and there are no combinational loops from in_ready to in_valid.
- Transfer occurs when in_valid[g] && in_ready[g]. On the next edge: out_data<=in_data[g], out_chan<=g, out_valid<=1.
- If load_en=1 and there is no grant: out_valid<=0 (drained) and out_data/out_chan hold their values.
- If load_en=0: output registers hold and all in_ready=0.
- ptr updates only on a transfer in round-robin mode: ptr<=(g+1) mod N, wrapping N-1 -> 0. In other modes ptr holds.
- Mode or sel changes take effect on the same cycle's grant computation. ptr is retained across mode switches.
- Latency: 1 cycle from accepted input to out_valid.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_chan are stable.
- Inputs: the block does not require in_data to stay stable on channels that are not granted.
- Reset mid-operation: any held word is discarded immediately (out_valid falls asynchronously) and ptr returns to 0.
- Non-power-of-2 N: indices >=N never appear on out_chan or in_ready.

Test Plan:
1. Reset with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0. After release in round-robin mode with out_ready=1 -> out_chan sequence 0,1,2,...,31,0, one word per cycle.
2. Fixed-priority, in_valid=32'h0000_0C00, out_ready=1 -> only in_ready[10] asserted. Drop channel 10 -> channel 11 granted next cycle.
3. Round-robin, in_valid=32'h8000_0001, N=32 -> grants alternate 0,31,0,31. Check the ptr wrap 31 -> 0.
4. Back-pressure: out_ready=0 for 5 cycles after a word from channel 3 with in_data[3]=32'hCA88_F0C3 -> out_data stable, in_ready=0 throughout. Then out_ready=1 -> the next word loads the same cycle the held word drains.
5. Directed mode, sel=5, in_valid[5]=0, in_valid[6]=1 -> no grant, out_valid falls after drain. With N=24 and sel=30 -> never a grant.
6. Assert reset_n=0 while out_valid=1 mid-stream -> out_valid=0 immediately. After release, round-robin restarts at channel 0.
